// File: rtl/div_feeder_if.sv
// rtl/div_feeder_if.sv - request, divider and response signals of div_feeder
interface div_feeder_if #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
);
  logic                     req_vld;
  logic                     req_rdy;
  logic [DW-1:0]            req_dividend;
  logic [DW-1:0]            req_divisor;
  logic                     div_in_vld;
  logic [DW-1:0]            div_dividend;
  logic [DW-1:0]            div_divisor;
  logic                     div_out_vld;
  logic [DW-1:0]            div_quotient;
  logic [DW-1:0]            div_remainder;
  logic                     rsp_vld;
  logic                     rsp_rdy;
  logic [DW-1:0]            rsp_quotient;
  logic [DW-1:0]            rsp_remainder;
  logic                     rsp_dz;
  logic [$clog2(DEPTH):0]   level;

  modport slave (
    input  req_vld, req_dividend, req_divisor,
    output req_rdy,
    output div_in_vld, div_dividend, div_divisor,
    input  div_out_vld, div_quotient, div_remainder,
    output rsp_vld, rsp_quotient, rsp_remainder, rsp_dz,
    input  rsp_rdy,
    output level
  );

  modport master (
    output req_vld, req_dividend, req_divisor,
    input  req_rdy,
    input  div_in_vld, div_dividend, div_divisor,
    output div_out_vld, div_quotient, div_remainder,
    input  rsp_vld, rsp_quotient, rsp_remainder, rsp_dz,
    output rsp_rdy,
    input  level
  );
endinterface

// File: rtl/div_feeder.sv
// rtl/div_feeder.sv - operand FIFO and sequencer feeding a multi-cycle divider
// Optional DIV_ZERO_BYPASS_EN answers zero divisors locally without using the divider.
module div_feeder #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  div_feeder_if.slave    bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(DW + 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
`ifdef DIV_ZERO_BYPASS_EN
    , BYPASS
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [DW-1:0]   dvd_mem_q [DEPTH];
  logic [DW-1:0]   dvd_mem_d [DEPTH];
  logic [DW-1:0]   dvs_mem_q [DEPTH];
  logic [DW-1:0]   dvs_mem_d [DEPTH];
  logic            rsp_vld_q, rsp_vld_d;
  logic [DW-1:0]   rsp_quo_q, rsp_quo_d;
  logic [DW-1:0]   rsp_rem_q, rsp_rem_d;
`ifdef DIV_ZERO_BYPASS_EN
  logic            rsp_dz_q, rsp_dz_d;
`endif

  logic            req_rdy;
  logic            push;
  logic            pop;
  logic [DW-1:0]   head_dvd;
  logic [DW-1:0]   head_dvs;

  assign req_rdy  = (level_q != LW'(DEPTH));
  assign push     = bus.req_vld && req_rdy;
  assign head_dvd = dvd_mem_q[rd_ptr_q];
  assign head_dvs = dvs_mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    dvd_mem_d = dvd_mem_q;
    dvs_mem_d = dvs_mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    if (push) begin
      dvd_mem_d[wr_ptr_q] = bus.req_dividend;
      dvs_mem_d[wr_ptr_q] = bus.req_divisor;
      wr_ptr_d            = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pop       = 1'b0;
    rsp_vld_d = rsp_vld_q;
    rsp_quo_d = rsp_quo_q;
    rsp_rem_d = rsp_rem_q;
`ifdef DIV_ZERO_BYPASS_EN
    rsp_dz_d  = rsp_dz_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (level_q != '0) begin
`ifdef DIV_ZERO_BYPASS_EN
          if (head_dvs == '0) state_d = BYPASS;
          else                state_d = ISSUE;
`else
          state_d = ISSUE;
`endif
        end
      end
      ISSUE: begin
        // Divider needs in_vld held for DW+1 cycles to run its iterations.
        if (cnt_q == CW'(DW)) state_d = WAIT;
        else                  cnt_d   = cnt_q + 1'b1;
      end
      WAIT: begin
        if (bus.div_out_vld) begin
          rsp_quo_d = bus.div_quotient;
          rsp_rem_d = bus.div_remainder;
`ifdef DIV_ZERO_BYPASS_EN
          rsp_dz_d  = 1'b0;
`endif
          rsp_vld_d = 1'b1;
          pop       = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (rsp_vld_q && bus.rsp_rdy) begin
          rsp_vld_d = 1'b0;
          state_d   = IDLE;
        end
      end
`ifdef DIV_ZERO_BYPASS_EN
      BYPASS: begin
        rsp_quo_d = '1;
        rsp_rem_d = head_dvd;
        rsp_dz_d  = 1'b1;
        rsp_vld_d = 1'b1;
        pop       = 1'b1;
        state_d   = RESP;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      rsp_vld_q <= 1'b0;
      rsp_quo_q <= '0;
      rsp_rem_q <= '0;
`ifdef DIV_ZERO_BYPASS_EN
      rsp_dz_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_quo_q <= rsp_quo_d;
      rsp_rem_q <= rsp_rem_d;
`ifdef DIV_ZERO_BYPASS_EN
      rsp_dz_q  <= rsp_dz_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    dvd_mem_q <= dvd_mem_d;
    dvs_mem_q <= dvs_mem_d;
  end

  assign bus.req_rdy       = req_rdy;
  assign bus.level         = level_q;
  assign bus.div_in_vld    = (state_q == ISSUE);
  assign bus.div_dividend  = head_dvd;
  assign bus.div_divisor   = head_dvs;
  assign bus.rsp_vld       = rsp_vld_q;
  assign bus.rsp_quotient  = rsp_quo_q;
  assign bus.rsp_remainder = rsp_rem_q;
`ifdef DIV_ZERO_BYPASS_EN
  assign bus.rsp_dz        = rsp_dz_q;
`else
  assign bus.rsp_dz        = 1'b0;
`endif
endmodule

// File: tb/tb_div_feeder.sv
// tb/tb_div_feeder.sv - directed bench for div_feeder with a behavioural divider
module tb_div_feeder;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
`ifdef DIV_ZERO_BYPASS_EN
  localparam int DZ_LAT  = 3;
  localparam int DZ_FLAG = 1;
`else
  localparam int DZ_LAT  = 12;
  localparam int DZ_FLAG = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_feeder_if #(.DW(DW), .DEPTH(DEPTH)) bus ();
  div_feeder #(.DW(DW), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int vectors     = 0;
  int miscompares = 0;
  int dcnt;

  // Divider: result strobe one cycle after in_vld has been seen DW+1 cycles.
  always @(posedge clk) begin
    if (rst) begin
      dcnt              <= 0;
      bus.div_out_vld   <= 1'b0;
      bus.div_quotient  <= '0;
      bus.div_remainder <= '0;
    end else begin
      bus.div_out_vld <= 1'b0;
      if (bus.div_in_vld) begin
        if (dcnt == DW) begin
          dcnt            <= 0;
          bus.div_out_vld <= 1'b1;
          if (bus.div_divisor == '0) begin
            bus.div_quotient  <= '1;
            bus.div_remainder <= bus.div_dividend;
          end else begin
            bus.div_quotient  <= bus.div_dividend / bus.div_divisor;
            bus.div_remainder <= bus.div_dividend % bus.div_divisor;
          end
        end else begin
          dcnt <= dcnt + 1;
        end
      end else begin
        dcnt <= 0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b);
    int n;
    bus.req_dividend = a;
    bus.req_divisor  = b;
    bus.req_vld      = 1'b1;
    n = 0;
    while (!bus.req_rdy && n < 100) begin
      tick();
      n++;
    end
    check("push_rdy", 32'(bus.req_rdy), 32'd1);
    tick();
    bus.req_vld = 1'b0;
  endtask

  task automatic expect_rsp(input string tag, input logic [7:0] q, input logic [7:0] r);
    int n;
    n = 0;
    while (!bus.rsp_vld && n < 60) begin
      tick();
      n++;
    end
    check({tag, "_vld"}, 32'(bus.rsp_vld), 32'd1);
    check({tag, "_quo"}, 32'(bus.rsp_quotient), 32'(q));
    check({tag, "_rem"}, 32'(bus.rsp_remainder), 32'(r));
    tick();
  endtask

  initial begin
    int n;
    rst              = 1'b1;
    bus.req_vld      = 1'b0;
    bus.req_dividend = '0;
    bus.req_divisor  = '0;
    bus.rsp_rdy      = 1'b0;
    repeat (3) tick();

    check("rst_req_rdy", 32'(bus.req_rdy), 32'd1);
    check("rst_level", 32'(bus.level), 32'd0);
    check("rst_in_vld", 32'(bus.div_in_vld), 32'd0);
    check("rst_rsp_vld", 32'(bus.rsp_vld), 32'd0);
    check("rst_rsp_quo", 32'(bus.rsp_quotient), 32'd0);
    check("rst_rsp_rem", 32'(bus.rsp_remainder), 32'd0);
    check("rst_rsp_dz", 32'(bus.rsp_dz), 32'd0);
    rst = 1'b0;
    tick();

    // Single pair 100/7 accepted in cycle T
    bus.rsp_rdy      = 1'b1;
    bus.req_dividend = 8'd100;
    bus.req_divisor  = 8'd7;
    bus.req_vld      = 1'b1;
    tick();
    bus.req_vld = 1'b0;
    check("s_level", 32'(bus.level), 32'd1);
    for (int k = 1; k <= 14; k++) begin
      check("s_in_vld", 32'(bus.div_in_vld), 32'(k >= 2 && k <= 10));
      check("s_rsp_vld", 32'(bus.rsp_vld), 32'(k == 12));
      if (k == 2) check("s_head", 32'({bus.div_dividend, bus.div_divisor}), 32'h6407);
      if (k == 12) begin
        check("s_quo", 32'(bus.rsp_quotient), 32'd14);
        check("s_rem", 32'(bus.rsp_remainder), 32'd2);
        check("s_dz", 32'(bus.rsp_dz), 32'd0);
      end
      tick();
    end

    // Divide by zero 200/0
    bus.req_dividend = 8'd200;
    bus.req_divisor  = 8'd0;
    bus.req_vld      = 1'b1;
    tick();
    bus.req_vld = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      check("dz_in_vld", 32'(bus.div_in_vld), 32'(DZ_LAT == 12 && k >= 2 && k <= 10));
      check("dz_rsp_vld", 32'(bus.rsp_vld), 32'(k == DZ_LAT));
      if (k == DZ_LAT) begin
        check("dz_quo", 32'(bus.rsp_quotient), 32'd255);
        check("dz_rem", 32'(bus.rsp_remainder), 32'd200);
        check("dz_flag", 32'(bus.rsp_dz), 32'(DZ_FLAG));
      end
      tick();
    end

    // Fill with the response side stalled
    bus.rsp_rdy = 1'b0;
    push(8'd50, 8'd5);
    push(8'd77, 8'd10);
    push(8'd255, 8'd16);
    push(8'd9, 8'd4);
    check("fill_level", 32'(bus.level), 32'd4);
    check("fill_rdy", 32'(bus.req_rdy), 32'd0);
    push(8'd123, 8'd11);
    n = 0;
    while (!bus.rsp_vld && n < 60) begin
      tick();
      n++;
    end
    for (int i = 0; i < 20; i++) begin
      check("bp_rsp_vld", 32'(bus.rsp_vld), 32'd1);
      check("bp_quo", 32'(bus.rsp_quotient), 32'd10);
      check("bp_rem", 32'(bus.rsp_remainder), 32'd0);
      check("bp_in_vld", 32'(bus.div_in_vld), 32'd0);
      check("bp_req_rdy", 32'(bus.req_rdy), 32'd0);
      tick();
    end
    check("bp_level", 32'(bus.level), 32'd4);
    bus.rsp_rdy = 1'b1;
    expect_rsp("fill0", 8'd10, 8'd0);
    expect_rsp("fill1", 8'd7, 8'd7);
    expect_rsp("fill2", 8'd15, 8'd15);
    expect_rsp("fill3", 8'd2, 8'd1);
    expect_rsp("fill4", 8'd11, 8'd2);
    check("fill_empty", 32'(bus.level), 32'd0);

    // Push coincides with the pop of the head at level 3
    push(8'd10, 8'd3);
    push(8'd240, 8'd15);
    push(8'd99, 8'd100);
    n = 0;
    while (!bus.div_out_vld && n < 60) begin
      tick();
      n++;
    end
    check("sim_out_vld", 32'(bus.div_out_vld), 32'd1);
    check("sim_level_pre", 32'(bus.level), 32'd3);
    bus.req_dividend = 8'd1;
    bus.req_divisor  = 8'd1;
    bus.req_vld      = 1'b1;
    tick();
    bus.req_vld = 1'b0;
    check("sim_level_post", 32'(bus.level), 32'd3);
    expect_rsp("sim0", 8'd3, 8'd1);
    expect_rsp("sim1", 8'd16, 8'd0);
    expect_rsp("sim2", 8'd0, 8'd99);
    expect_rsp("sim3", 8'd1, 8'd0);

    // Reset in the middle of ISSUE
    push(8'd60, 8'd7);
    repeat (4) tick();
    check("mid_in_vld_pre", 32'(bus.div_in_vld), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_in_vld", 32'(bus.div_in_vld), 32'd0);
    check("mid_level", 32'(bus.level), 32'd0);
    check("mid_rsp_vld", 32'(bus.rsp_vld), 32'd0);
    check("mid_req_rdy", 32'(bus.req_rdy), 32'd1);
    push(8'd255, 8'd255);
    expect_rsp("post_rst", 8'd1, 8'd0);
    check("post_rst_level", 32'(bus.level), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/div_feeder.md
DIV_FEEDER -- requirements
Module: div_feeder

Interface
REQ-001 SHALL have parameter DW, default 8, operand/result width; must match the downstream sequential divider.
REQ-002 SHALL have parameter DEPTH, default 4, operand FIFO entries; power of two, at least 2.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req_vld  input  1  upstream operand pair valid.
REQ-006 SHALL have port req_rdy  output  1  FIFO can accept a pair.
REQ-007 SHALL have ports req_dividend and req_divisor  input  DW each  operands.
REQ-008 SHALL have port div_in_vld  output  1  drives the divider's in_vld.
REQ-009 SHALL have ports div_dividend and div_divisor  output  DW each  FIFO head operands to the divider.
REQ-010 SHALL have port div_out_vld  input  1  divider result strobe.
REQ-011 SHALL have ports div_quotient and div_remainder  input  DW each  divider results.
REQ-012 SHALL have port rsp_vld  output  1  response valid.
REQ-013 SHALL have port rsp_rdy  input  1  downstream accepts the response.
REQ-014 SHALL have ports rsp_quotient and rsp_remainder  output  DW each  registered result.
REQ-015 SHALL have port rsp_dz  output  1  divide-by-zero flag.
REQ-016 SHALL have port level  output  $clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-017 SHALL accept a pair into the FIFO on each cycle with req_vld and req_rdy high; req_rdy = (level != DEPTH).
REQ-018 SHALL use FSM states IDLE, ISSUE, WAIT and RESP.
REQ-019 IDLE SHALL move to ISSUE when level != 0; otherwise it SHALL stay in IDLE.
REQ-020 ISSUE SHALL hold div_in_vld high, with div_dividend and div_divisor stable at the FIFO head, for exactly DW+1 consecutive cycles (counter 0..DW), then SHALL move to WAIT.
REQ-021 WAIT SHALL hold div_in_vld low; on div_out_vld it SHALL load div_quotient and div_remainder into the rsp registers, pop the FIFO head, set rsp_vld and move to RESP.
REQ-022 RESP SHALL hold rsp_vld and the data stable until rsp_rdy; on rsp_vld and rsp_rdy it SHALL clear rsp_vld and return to IDLE.
REQ-023 div_out_vld in IDLE, ISSUE or RESP SHALL be ignored.
REQ-024 Latency: a pair accepted in cycle T, with the FIFO empty and the FSM in IDLE, SHALL produce rsp_vld first high in cycle T+DW+4.
REQ-025 A push and a pop in the same cycle SHALL leave level unchanged, and the write SHALL succeed even when level == DEPTH-1.
REQ-026 FIFO pointers SHALL wrap modulo DEPTH; the order of responses SHALL equal the order of requests.
REQ-027 level SHALL never exceed DEPTH, and a pop when level == 0 SHALL never occur.

Reset
REQ-028 While rst is high at a clock edge, the FSM SHALL go to IDLE and the FIFO pointers and level SHALL go to 0.
REQ-029 On reset, div_in_vld, rsp_vld and rsp_dz SHALL go to 0, and rsp_quotient and rsp_remainder SHALL go to 0.
REQ-030 On reset, req_rdy SHALL be 1 from the first cycle after reset.
REQ-031 Reset mid-operation SHALL abandon the current pair and drop div_in_vld the next cycle; the divider SHALL share the same reset.

Configuration
REQ-032 With DIV_ZERO_BYPASS_EN defined, a head divisor of 0 SHALL skip ISSUE and WAIT: the FSM SHALL go from IDLE straight to loading rsp_quotient = all ones, rsp_remainder = dividend and rsp_dz = 1, pop the FIFO and enter RESP, giving rsp_vld at T+3.
REQ-033 With DIV_ZERO_BYPASS_EN defined, rsp_dz SHALL be 0 for every non-zero divisor.
REQ-034 Without DIV_ZERO_BYPASS_EN, a zero divisor SHALL be issued like any other pair and the divider result SHALL be passed through.
REQ-035 Without DIV_ZERO_BYPASS_EN, rsp_dz SHALL be constant 0.

Verification (DW=8, DEPTH=4)
REQ-036 Single pair: push 100/7 at T with rsp_rdy=1 -> div_in_vld high T+2..T+10; rsp_vld at T+12 with quotient 14, remainder 2.
REQ-037 Fill: hold rsp_rdy=0 and push 5 pairs back-to-back -> req_rdy low once level=4; all pairs are returned in order after rsp_rdy is raised.
REQ-038 Backpressure: hold rsp_rdy low for 20 cycles -> rsp_vld and rsp data stay stable, no new div_in_vld, and the FIFO keeps accepting until full.
REQ-039 Divide by zero: push 200/0 -> with the macro, rsp at T+3 with quotient 255, remainder 200, rsp_dz=1; without the macro, rsp at T+12 with rsp_dz=0.
REQ-040 Reset mid-ISSUE: assert rst at T+5 of a transfer -> next cycle div_in_vld=0, level=0, rsp_vld=0; a subsequent push 255/255 returns 1/0.
REQ-041 Simultaneous push and pop at level=3 -> level stays 3 and no data is lost or duplicated.
